// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the IF/ID pipeline slice.
package core_pkg;
    localparam int CORE_XLEN = 32;
    localparam logic [CORE_XLEN-1:0] NOP_INST = 32'h00000013;

    typedef enum logic {SIG_LO, SIG_HI} onebit_sig_e;

    typedef struct packed {
        logic                 valid;
        logic [CORE_XLEN-1:0] pc;
        logic [CORE_XLEN-1:0] inst;
    } if_id_t;

    typedef enum logic [1:0] {EMPTY, RUN, BUF} if_id_state_e;
endpackage

// File: rtl/skid_fifo.sv
// skid_fifo: small FIFO with wrap-around pointers; the extra pointer MSB separates full from empty.
module skid_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [31:0]
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  T                       din_i,
    input  logic                   pop_i,
    output T                       dout_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);

    T           r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;

    assign count_o = r_wptr - r_rptr;
    assign empty_o = r_wptr == r_rptr;
    assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign dout_o  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (push_i) r_wptr <= r_wptr + 1'b1;
            if (pop_i)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) r_mem[r_wptr[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID register with a skid FIFO that absorbs fetch beats while decode stalls.
module if_id_stage
    import core_pkg::*;
#(
    parameter int             XLEN       = CORE_XLEN,
    parameter int             SKID_DEPTH = 2,
    parameter logic [XLEN-1:0] NOP_INST  = core_pkg::NOP_INST,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          if_valid_i,
    input  logic [XLEN-1:0]               if_pc_i,
    input  logic [XLEN-1:0]               if_inst_i,
    output logic                          if_ready_o,
    input  logic                          insert_bubble_i,
    input  logic                          flush_i,
    output logic                          id_valid_o,
    output logic [XLEN-1:0]               id_pc_o,
    output logic [XLEN-1:0]               id_inst_o,
    output logic                          id_fire_o,
    output logic [$clog2(SKID_DEPTH):0]   skid_count_o,
    output logic [15:0]                   bubble_cnt_o
);
    localparam int CW = $clog2(SKID_DEPTH) + 1;

    if_id_t       r_id;
    if_id_state_e r_state;
    logic [15:0]  r_bub;
    if_id_t       w_in;
    if_id_t       w_head;
    logic [CW-1:0] w_count;
    logic         w_full;
    logic         w_empty;
    logic         w_accept;
    logic         w_adv;
    logic         w_pop;
    logic         w_push;

    assign w_in       = '{valid: 1'b1, pc: if_pc_i, inst: if_inst_i};
    assign if_ready_o = ~w_full & ~flush_i;
    assign w_accept   = if_valid_i & if_ready_o;
    assign w_adv      = ~insert_bubble_i;
    assign w_pop      = w_adv & ~flush_i & ~w_empty;
    // Bypass straight into IF/ID only when nothing older is queued.
    assign w_push     = w_accept & ~(w_adv & w_empty);

    skid_fifo #(.DEPTH(SKID_DEPTH), .T(if_id_t)) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (w_push),
        .din_i   (w_in),
        .pop_i   (w_pop),
        .dout_o  (w_head),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_id    <= '{valid: 1'b0, pc: RESET_PC, inst: NOP_INST};
            r_state <= EMPTY;
            r_bub   <= '0;
        end else if (flush_i) begin
            r_id.valid <= 1'b0;
            r_id.inst  <= NOP_INST;
            r_state    <= EMPTY;
        end else begin
            if (w_adv)
                r_id <= !w_empty ? w_head : w_accept ? w_in : '{valid: 1'b0, pc: r_id.pc, inst: NOP_INST};
            if (r_id.valid && insert_bubble_i && !(&r_bub))
                r_bub <= r_bub + 1'b1;
            case (r_state)
                EMPTY:   if (w_accept) r_state <= w_adv ? RUN : BUF;
                RUN:     if (w_accept && !w_adv) r_state <= BUF;
                         else if (w_adv && !w_accept) r_state <= EMPTY;
                BUF:     if (w_pop && !w_push && w_count == CW'(1)) r_state <= RUN;
                default: r_state <= EMPTY;
            endcase
        end
    end

    // The occupancy state must always agree with the datapath it summarises.
    a_state_consistent: assert property (@(posedge clk_i) disable iff (rst_i)
        ((r_state == BUF) == !w_empty) && ((r_state == RUN) == (w_empty && r_id.valid)));

    assign id_valid_o   = r_id.valid;
    assign id_pc_o      = r_id.pc;
    assign id_inst_o    = r_id.inst;
    assign id_fire_o    = r_id.valid & ~insert_bubble_i;
    assign skid_count_o = w_count;
    assign bubble_cnt_o = r_bub;
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: queue-based reference model plus directed scenarios for if_id_stage.
module tb_if_id_stage;
    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_valid_i = 1'b0;
    logic [31:0] if_pc_i = '0;
    logic [31:0] if_inst_i = '0;
    logic        insert_bubble_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        if_ready_o;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_fire_o;
    logic [1:0]  skid_count_o;
    logic [15:0] bubble_cnt_o;

    int checks = 0;
    int failures = 0;

    if_id_stage dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .if_valid_i      (if_valid_i),
        .if_pc_i         (if_pc_i),
        .if_inst_i       (if_inst_i),
        .if_ready_o      (if_ready_o),
        .insert_bubble_i (insert_bubble_i),
        .flush_i         (flush_i),
        .id_valid_o      (id_valid_o),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .id_fire_o       (id_fire_o),
        .skid_count_o    (skid_count_o),
        .bubble_cnt_o    (bubble_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: IF/ID contents plus a queue of waiting beats in program order.
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [63:0] m_q[$];
    int          m_bub;

    function automatic logic m_ready();
        return (m_q.size() < DEPTH) && !flush_i;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 1'b0;
            m_pc    = '0;
            m_inst  = NOP;
            m_q.delete();
            m_bub   = 0;
        end else begin
            logic acc;
            logic [63:0] e;
            acc = if_valid_i && m_ready();
            if (m_valid && insert_bubble_i && !flush_i && m_bub < 65535) m_bub++;
            if (flush_i) begin
                m_q.delete();
                m_valid = 1'b0;
                m_inst  = NOP;
            end else if (!insert_bubble_i) begin
                if (m_q.size() > 0) begin
                    e = m_q.pop_front();
                    {m_pc, m_inst} = e;
                    m_valid = 1'b1;
                    if (acc) m_q.push_back({if_pc_i, if_inst_i});
                end else if (acc) begin
                    m_pc    = if_pc_i;
                    m_inst  = if_inst_i;
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                    m_inst  = NOP;
                end
            end else if (acc) begin
                m_q.push_back({if_pc_i, if_inst_i});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("valid", id_valid_o, m_valid);
            chk("pc", id_pc_o, m_pc);
            chk("inst", id_inst_o, m_inst);
            chk("ready", if_ready_o, m_ready());
            chk("fire", id_fire_o, m_valid && !insert_bubble_i);
            chk("count", skid_count_o, m_q.size());
            chk("bubcnt", bubble_cnt_o, m_bub);
        end
    end

    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] in,
                       input logic b, input logic f);
        if_valid_i = v;
        if_pc_i = pc;
        if_inst_i = in;
        insert_bubble_i = b;
        flush_i = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", id_valid_o, 0);
        chk("rst_inst", id_inst_o, 32'h13);
        chk("rst_pc", id_pc_o, 0);
        chk("rst_count", skid_count_o, 0);
        chk("rst_bub", bubble_cnt_o, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("ready_after_rst", if_ready_o, 1);

        cyc(1, 32'h100, 32'h00500093, 0, 0);
        chk("first_valid", id_valid_o, 1);
        chk("first_pc", id_pc_o, 32'h100);
        chk("first_inst", id_inst_o, 32'h00500093);
        chk("first_fire", id_fire_o, 1);

        cyc(1, 32'h104, 32'h00600113, 1, 0);
        cyc(1, 32'h108, 32'h00700193, 1, 0);
        chk("stall_count", skid_count_o, 2);
        chk("stall_ready", if_ready_o, 0);
        chk("stall_bub", bubble_cnt_o, 2);
        chk("stall_pc", id_pc_o, 32'h100);
        chk("stall_fire", id_fire_o, 0);
        cyc(0, 0, 0, 0, 0);
        chk("drain1_pc", id_pc_o, 32'h104);
        chk("drain1_inst", id_inst_o, 32'h00600113);
        cyc(0, 0, 0, 0, 0);
        chk("drain2_pc", id_pc_o, 32'h108);
        chk("drain2_count", skid_count_o, 0);
        cyc(0, 0, 0, 0, 0);
        chk("idle_valid", id_valid_o, 0);
        chk("idle_inst", id_inst_o, 32'h13);

        cyc(1, 32'h110, 32'h11, 0, 0);
        cyc(1, 32'h114, 32'h22, 1, 0);
        cyc(1, 32'h118, 32'h33, 1, 0);
        chk("pre_flush_count", skid_count_o, 2);
        cyc(1, 32'h200, 32'h44, 1, 1);
        chk("flush_valid", id_valid_o, 0);
        chk("flush_count", skid_count_o, 0);
        chk("flush_inst", id_inst_o, 32'h13);
        chk("flush_pc", id_pc_o, 32'h110);
        chk("flush_bub", bubble_cnt_o, 4);
        cyc(0, 0, 0, 0, 0);
        chk("flush_no_accept", id_valid_o, 0);

        for (int i = 0; i < 60; i++)
            cyc((i % 3) != 0, 32'h300 + 32'(4 * i), 32'h1000 + 32'(i), (i % 5) < 2, (i % 17) == 16);

        cyc(1, 32'h500, 32'h55, 0, 0);
        cyc(1, 32'h504, 32'h66, 1, 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", id_valid_o, 0);
        chk("mid_rst_inst", id_inst_o, 32'h13);
        chk("mid_rst_count", skid_count_o, 0);
        chk("mid_rst_bub", bubble_cnt_o, 0);
        if_valid_i = 1'b0;
        insert_bubble_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        cyc(1, 32'h400, 32'h77, 0, 0);
        if_valid_i = 1'b0;
        insert_bubble_i = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_bub", bubble_cnt_o, 16'hFFFF);
        chk("sat_valid", id_valid_o, 1);
        chk("sat_pc", id_pc_o, 32'h400);
        cyc(0, 0, 0, 1, 0);
        chk("sat_hold", bubble_cnt_o, 16'hFFFF);
        cyc(0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
